// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite slave (typically the AHB-to-APB bridge) between NUM_REQ requesters.
// Optional data-phase watchdog and sticky o_timeout output are enabled with `define ARB_TIMEOUT_EN.
module apb_bridge_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQ-1:0]               i_req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
    output logic [NUM_REQ-1:0]               o_gnt,
    output logic [NUM_REQ-1:0]               o_done,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_err,
    output logic [ADDR_WIDTH-1:0]            o_haddr,
    output logic [1:0]                       o_htrans,
    output logic                             o_hwrite,
    output logic [2:0]                       o_hsize,
    output logic [2:0]                       o_hburst,
    output logic [3:0]                       o_hprot,
    output logic                             o_hmasterlock,
    output logic [DATA_WIDTH-1:0]            o_hwdata,
    output logic                             o_hreadyin,
    input  logic                             i_hreadyout,
    input  logic [DATA_WIDTH-1:0]            i_hrdata,
    input  logic                             i_hresp
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                             o_timeout
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           gidx_q, gidx_d;
    logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
    logic                    hwrite_q, hwrite_d;
    logic [1:0]              htrans_q, htrans_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    complete;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0]           tcnt_q, tcnt_d;
    logic                    timeout_q, timeout_d;
`endif

    // A requester whose done pulse is visible this cycle is not eligible yet.
    logic [NUM_REQ-1:0]      elig;
    logic                    pick_vld;
    logic [PW-1:0]           pick_idx;
    int unsigned             cand;

    always_comb begin
        elig     = i_req & ~done_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!pick_vld && elig[PW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        htrans_d = htrans_q;
        wdata_d  = wdata_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        complete = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    haddr_d         = i_req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    hwrite_d        = i_req_write[pick_idx];
                    wdata_d         = i_req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    htrans_d        = HTRANS_NONSEQ;
                    state_d         = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_hreadyout) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                    state_d  = S_DATA;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d   = '0;
`endif
                end
            end
            S_DATA: begin
                if (i_hreadyout) begin
                    rdata_d  = hwrite_q ? '0 : i_hrdata;
                    err_d    = i_hresp;
                    complete = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    complete  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                htrans_d = HTRANS_IDLE;
            end
        endcase

        if (complete) begin
            done_d[gidx_q] = 1'b1;
            gnt_d          = '0;
            ptr_d          = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            state_d        = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            ptr_q    <= '0;
            gidx_q   <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            wdata_q  <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            htrans_q <= htrans_d;
            wdata_q  <= wdata_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`endif

    assign o_gnt         = gnt_q;
    assign o_done        = done_q;
    assign o_rdata       = rdata_q;
    assign o_err         = err_q;
    assign o_haddr       = haddr_q;
    assign o_htrans      = htrans_q;
    assign o_hwrite      = hwrite_q;
    assign o_hwdata      = hwdata_q;
    assign o_hsize       = 3'b010;
    assign o_hburst      = 3'b000;
    assign o_hprot       = 4'b0011;
    assign o_hmasterlock = 1'b0;
    assign o_hreadyin    = i_hreadyout;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Self-checking bench for apb_bridge_arbiter: directed scenarios plus randomized requesters/slave
// checked every cycle against a transaction-level reference model.
module tb_apb_bridge_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req       = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic            hready    = 1'b1;
    logic            hresp     = 1'b0;
    logic [DW-1:0]   hrdata    = '0;

    logic [N-1:0]  o_gnt, o_done;
    logic [DW-1:0] o_rdata, o_hwdata;
    logic          o_err, o_hwrite, o_hmasterlock, o_hreadyin;
    logic [AW-1:0] o_haddr;
    logic [1:0]    o_htrans;
    logic [2:0]    o_hsize, o_hburst;
    logic [3:0]    o_hprot;
`ifdef ARB_TIMEOUT_EN
    logic          o_timeout;
`endif

    apb_bridge_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req(req), .i_req_addr(req_addr), .i_req_write(req_write), .i_req_wdata(req_wdata),
        .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hwrite(o_hwrite), .o_hsize(o_hsize),
        .o_hburst(o_hburst), .o_hprot(o_hprot), .o_hmasterlock(o_hmasterlock),
        .o_hwdata(o_hwdata), .o_hreadyin(o_hreadyin),
        .i_hreadyout(hready), .i_hrdata(hrdata), .i_hresp(hresp)
`ifdef ARB_TIMEOUT_EN
        , .o_timeout(o_timeout)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, phase 0=idle, 1=address, 2=data.
    int            m_phase = 0, m_g = 0, m_ptr = 0, m_tcnt = 0, m_c = 0;
    bit            m_found;
    logic [N-1:0]  m_elig;
    logic [N-1:0]  e_gnt = '0, e_done = '0;
    logic [1:0]    e_htrans = '0;
    logic [AW-1:0] e_haddr = '0;
    logic          e_hwrite = 1'b0, e_err = 1'b0, e_timeout = 1'b0;
    logic [DW-1:0] e_hwdata = '0, e_rdata = '0, m_wdata = '0;

    task automatic model_finish(input logic [DW-1:0] rd, input logic er);
        e_rdata = rd;
        e_err   = er;
        e_done  = N'(1) << m_g;
        e_gnt   = '0;
        m_ptr   = (m_g + 1) % N;
        m_phase = 0;
    endtask

    // Runs after inputs settle, predicting DUT outputs after the coming rising edge.
    initial forever begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            m_phase = 0; m_g = 0; m_ptr = 0; m_tcnt = 0;
            e_gnt = '0; e_done = '0; e_htrans = '0; e_haddr = '0; e_hwrite = 1'b0;
            e_hwdata = '0; e_rdata = '0; m_wdata = '0; e_err = 1'b0; e_timeout = 1'b0;
        end else begin
            m_elig = req & ~e_done;
            e_done = '0;
            if (m_phase == 0) begin
                m_found = 1'b0;
                for (int s = 0; s < N; s++) begin
                    m_c = (m_ptr + s) % N;
                    if (!m_found && m_elig[m_c]) begin
                        m_found = 1'b1;
                        m_g     = m_c;
                    end
                end
                if (m_found) begin
                    e_gnt    = N'(1) << m_g;
                    e_haddr  = req_addr[m_g*AW +: AW];
                    e_hwrite = req_write[m_g];
                    m_wdata  = req_wdata[m_g*DW +: DW];
                    e_htrans = 2'b10;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                if (hready) begin
                    e_htrans = 2'b00;
                    e_hwdata = e_hwrite ? m_wdata : '0;
                    m_tcnt   = 0;
                    m_phase  = 2;
                end
            end else begin
                if (hready) model_finish(e_hwrite ? '0 : hrdata, hresp);
`ifdef ARB_TIMEOUT_EN
                else if (m_tcnt + 1 >= TO) begin
                    model_finish('0, 1'b1);
                    e_timeout = 1'b1;
                end else m_tcnt++;
`endif
            end
        end
    end

    // Compare process: every cycle out of reset.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("gnt", o_gnt, e_gnt);
            chk("done", o_done, e_done);
            chk("htrans", o_htrans, e_htrans);
            chk("hreadyin", o_hreadyin, hready);
            chk("hsize", o_hsize, 3'b010);
            chk("hburst", o_hburst, 3'b000);
            chk("hprot", o_hprot, 4'b0011);
            chk("hmasterlock", o_hmasterlock, 1'b0);
            if (m_phase != 0) begin
                chk("haddr", o_haddr, e_haddr);
                chk("hwrite", o_hwrite, e_hwrite);
            end
            if (m_phase == 2) chk("hwdata", o_hwdata, e_hwdata);
            if (e_done != '0) begin
                chk("rdata", o_rdata, e_rdata);
                chk("err", o_err, e_err);
            end
`ifdef ARB_TIMEOUT_EN
            chk("timeout", o_timeout, e_timeout);
`endif
        end
    end

    // Slave: wait states and response scripted per transfer (random in rand_mode).
    bit            rand_mode = 1'b0;
    int            sl_aw = 0, sl_dw = 0, sl_cnt = 0, sl_last = 0;
    bit            sl_err = 1'b0;
    logic [DW-1:0] sl_rd = '0;

    initial forever begin
        @(negedge clk);
        #2;
        if (m_phase != sl_last) begin
            sl_cnt = 0;
            if (m_phase == 1 && rand_mode) begin
                sl_aw  = $urandom_range(0, 2);
                sl_dw  = $urandom_range(0, 3);
                sl_err = ($urandom_range(0, 4) == 0);
                if (sl_err && sl_dw == 0) sl_dw = 1;
                sl_rd  = $urandom;
            end
        end
        sl_last = m_phase;
        case (m_phase)
            1: begin hready = (sl_cnt >= sl_aw); hresp = 1'b0; end
            2: begin
                hready = (sl_cnt >= sl_dw);
                hresp  = sl_err && (sl_cnt + 1 >= sl_dw);
                hrdata = (sl_cnt >= sl_dw) ? sl_rd : DW'($urandom);
            end
            default: begin hready = 1'($urandom_range(0, 1)); hresp = 1'b0; end
        endcase
        sl_cnt++;
    end

    // Random requesters: hold req until done, occasionally drop it while granted.
    logic [N-1:0] pending = '0;
    initial forever begin
        @(negedge clk);
        #2;
        if (rand_mode && rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (e_done[k]) pending[k] = 1'b0;
                if (!pending[k] && $urandom_range(0, 2) == 0) begin
                    pending[k]              = 1'b1;
                    req_addr[k*AW +: AW]    = $urandom;
                    req_write[k]            = 1'($urandom_range(0, 1));
                    req_wdata[k*DW +: DW]   = $urandom;
                end
                req[k] = pending[k];
                if (m_phase != 0 && m_g == k && $urandom_range(0, 3) == 0) req[k] = 1'b0;
            end
        end
    end

    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (!o_done[k] && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", o_done[k], 1'b1);
    endtask

    int cyc, acyc, n;
    int seq [6];
    int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [1:0] prev_htrans;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_gnt", o_gnt, 4'b0000);
        chk("rst_htrans", o_htrans, 2'b00);
        chk("rst_done", o_done, 4'b0000);
        chk("rst_haddr", o_haddr, 32'h0);
        #1 rst_n = 1'b1;

        // Read with 3 data-phase wait states
        @(negedge clk); #2;
        req_addr[0*AW +: AW] = 32'h1000_0010; req_write[0] = 1'b0;
        sl_aw = 0; sl_dw = 3; sl_rd = 32'hCAFE_0001; sl_err = 1'b0;
        req[0] = 1'b1;
        @(negedge clk);
        chk("t1_nonseq", o_htrans, 2'b10);
        chk("t1_gnt", o_gnt, 4'b0001);
        chk("t1_addr", o_haddr, 32'h1000_0010);
        wait_done(0, cyc);
        chk("t1_latency", cyc, 5);
        chk("t1_rdata", o_rdata, 32'hCAFE_0001);
        chk("t1_err", o_err, 1'b0);
        #2 req[0] = 1'b0;

        // Write
        @(negedge clk); #2;
        req_addr[2*AW +: AW] = 32'h20; req_write[2] = 1'b1; req_wdata[2*DW +: DW] = 32'hA5A5_5A5A;
        sl_aw = 1; sl_dw = 2; sl_err = 1'b0;
        req[2] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (o_gnt[2] && o_htrans == 2'b00) chk("t2_hwdata", o_hwdata, 32'hA5A5_5A5A);
        end while (!o_done[2] && cyc < 60);
        chk("t2_done", o_done, 4'b0100);
        chk("t2_rdata", o_rdata, 32'h0);
        #2 req[2] = 1'b0;

        // Address-phase stall then two-cycle ERROR response
        @(negedge clk); #2;
        req_addr[1*AW +: AW] = 32'h4; req_write[1] = 1'b0;
        sl_aw = 2; sl_dw = 1; sl_err = 1'b1; sl_rd = 32'h1234_5678;
        req[1] = 1'b1;
        cyc = 0; acyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (o_htrans == 2'b10) begin
                acyc++;
                chk("t4_haddr_stable", o_haddr, 32'h4);
            end
        end while (!o_done[1] && cyc < 60);
        chk("t4_addr_cycles", acyc, 3);
        chk("t4_done", o_done, 4'b0010);
        chk("t4_err", o_err, 1'b1);
        #2 req[1] = 1'b0;

        // Reset in the middle of a data phase
        @(negedge clk); #2;
        req_addr[3*AW +: AW] = 32'h30; req_write[3] = 1'b0;
        sl_aw = 0; sl_dw = 20; sl_err = 1'b0;
        req[3] = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(o_gnt[3] && o_htrans == 2'b00) && cyc < 60);
        chk("t5_in_data", o_gnt, 4'b1000);
        @(negedge clk);
        #1 rst_n = 1'b0; req = '0;
        #1;
        chk("t5_gnt", o_gnt, 4'b0000);
        chk("t5_htrans", o_htrans, 2'b00);
        chk("t5_haddr", o_haddr, 32'h0);
        chk("t5_hwrite", o_hwrite, 1'b0);
        chk("t5_hwdata", o_hwdata, 32'h0);
        chk("t5_rdata", o_rdata, 32'h0);
        chk("t5_err", o_err, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("t5_nodone", o_done, 4'b0000);
        end
        #1 rst_n = 1'b1;

        // Round-robin with req = 1011 held; first grant after reset must be 0
        @(negedge clk); #2;
        req_addr[0*AW +: AW] = 32'h100; req_addr[1*AW +: AW] = 32'h104; req_addr[3*AW +: AW] = 32'h10C;
        req_write = '0;
        sl_aw = 0; sl_dw = 0; sl_err = 1'b0;
        req = 4'b1011;
        n = 0; cyc = 0; prev_htrans = 2'b00;
        while (n < 6 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (o_htrans == 2'b10 && prev_htrans != 2'b10) begin
                for (int k = 0; k < N; k++) if (o_gnt[k]) seq[n] = k;
                n++;
            end
            prev_htrans = o_htrans;
        end
        #2 req = '0;
        chk("t3_count", n, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), seq[i], exp_seq[i]);
        repeat (10) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: slave stuck not-ready in the data phase
        @(negedge clk); #2;
        req_addr[0*AW +: AW] = 32'h200; req_write[0] = 1'b0;
        sl_aw = 0; sl_dw = 1000; sl_err = 1'b0;
        req[0] = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(o_gnt[0] && o_htrans == 2'b00) && cyc < 60);
        wait_done(0, cyc);
        chk("t6_latency", cyc, 16);
        chk("t6_err", o_err, 1'b1);
        chk("t6_rdata", o_rdata, 32'h0);
        #2 req[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_sticky", o_timeout, 1'b1);
        sl_dw = 0;
`endif

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (3000) @(negedge clk);
        #1 rand_mode = 1'b0; req = '0; pending = '0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_bridge_arbiter.md
Name: apb_bridge_arbiter

Overview:
Shares one AHB-Lite slave resource, normally the AHB-to-APB bridge, between NUM_REQ simple requesters. Each requester posts a single-word read or write on a req/done handshake. The block arbitrates round-robin, sequences one AHB-Lite NONSEQ SINGLE transfer at a time (address phase, then data phase), and returns read data and the error status to the granted requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 255, data-phase watchdog limit (only with ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  request per requester; held until matching o_done
i_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice k belongs to requester k
i_req_write  in  NUM_REQ  1 = write, 0 = read
i_req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
o_gnt  out  NUM_REQ  one-hot grant; held for the whole transfer
o_done  out  NUM_REQ  one-cycle completion pulse
o_rdata  out  DATA_WIDTH  read data; valid while o_done is high
o_err  out  1  error status; valid while o_done is high
o_haddr  out  ADDR_WIDTH  AHB address
o_htrans  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
o_hwrite  out  1  AHB write
o_hsize  out  3  constant 3'b010
o_hburst  out  3  constant 3'b000 (SINGLE)
o_hprot  out  4  constant 4'b0011
o_hmasterlock  out  1  constant 0
o_hwdata  out  DATA_WIDTH  AHB write data
o_hreadyin  out  1  equals i_hreadyout (AHB-Lite HREADY feedback to the slave)
i_hreadyout  in  1  slave ready
i_hrdata  in  DATA_WIDTH  slave read data
i_hresp  in  1  slave response: 0 = OKAY, 1 = ERROR

Behaviour:
- Reset: state S_IDLE; all registered outputs 0; o_htrans = IDLE; round-robin pointer = 0.
- Reset is honoured at any point. Reset mid-transfer aborts immediately: no o_done, grant cleared.
- S_IDLE:
  - Ignores i_req[k] in any cycle where o_done[k] = 1.
  - If any other request is high, picks the first set bit searching upward from the pointer with wrap-around.
  - Registers o_gnt, o_haddr, o_hwrite and an internal wdata latch from that requester's slices; sets o_htrans = NONSEQ; goes to S_ADDR.
  - Latency from a request sampled high to o_htrans = NONSEQ is 1 cycle.
- S_ADDR:
  - NONSEQ and address are held stable.
  - On an edge with i_hreadyout = 1: o_htrans becomes IDLE, o_hwdata takes the latch if write (else 0), go to S_DATA.
  - On an edge with i_hreadyout = 0: stay in S_ADDR.
- S_DATA:
  - o_hwdata is held.
  - On an edge with i_hreadyout = 1: o_rdata takes i_hrdata if read (else 0); o_err = i_hresp; o_done[g] pulses for 1 cycle; o_gnt is cleared; pointer = (g+1) mod NUM_REQ; go to S_IDLE.
  - A two-cycle ERROR response (hresp=1 with hready=0, then hresp=1 with hready=1) completes on the second cycle with o_err = 1.
- A request dropped while granted does not cancel the transfer; it still completes and pulses o_done.
- Request inputs are sampled only in S_IDLE; changes at any other time are ignored.
- At most one outstanding transfer. No pipelining of the next address phase into the current data phase.
- Unused encodings of the 2-bit state go to S_IDLE.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to S_DATA and counts cycles with i_hreadyout = 0.
  - On reaching TIMEOUT_CYCLES: complete with o_err = 1, o_rdata = 0, o_done pulse; pointer advances; return to S_IDLE.
  - Extra output o_timeout (1 bit) sets sticky and clears only on reset.
- Undefined: no counter and no o_timeout port; S_DATA waits indefinitely.

Test Plan:
1. Read: req[0] high, addr 0x1000_0010, slave returns 0xCAFE_0001 after 3 wait cycles. Expect NONSEQ one cycle after req, then done[0] with o_rdata = 0xCAFE_0001, o_err = 0.
2. Write: req[2] high, addr 0x20, wdata 0xA5A5_5A5A. Expect o_hwdata = 0xA5A5_5A5A throughout the data phase, done[2], o_rdata = 0.
3. Round-robin: req = 4'b1011 held continuously. Expect grant order 0, 1, 3, 0, 1, 3; requester 0 is not regranted in the cycle its o_done is high.
4. Error and stall: i_hreadyout = 0 for 2 cycles in S_ADDR, then a two-cycle ERROR response. Expect the address held stable and o_err = 1 with the done pulse.
5. Reset mid-transfer: assert i_reset_n = 0 during S_DATA. Expect all outputs 0 immediately, no o_done; after release, the first grant goes to requester 0.
6. With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, i_hreadyout stuck at 0 in S_DATA. Expect done with o_err = 1 after 16 cycles and o_timeout = 1 sticky.
